// File: rtl/mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter that shares one 8:1 bit mux between eight requesters.
// One requester owns the mux at a time. The owner's index drives the mux
// select. The grant is held until the owner pulses done, drops its request,
// or has held the mux for HOLD_MAX cycles. After every release there is
// exactly one idle cycle before the next owner is chosen.
//
// Parameters
//   HOLD_MAX  maximum number of cycles a grant is held (1..255)
//   CNT_W     width of the hold counter; HOLD_MAX must fit in it
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous, active-high reset
//   req      in   8  request vector; bit k = requester k wants the mux
//   done     in   1  1-cycle pulse from the current owner: transfer finished
//   sel      out  3  mux select (index of granted requester)
//   gnt      out  8  one-hot grant; all zero when there is no owner
//   busy     out  1  high while a grant is active
//   timeout  out  1  1-cycle pulse when a grant is forced off by HOLD_MAX
//
// All outputs are registered, so req and done have no combinational path
// to any output.
// -----------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       sel_nxt;
    logic [7:0]       gnt_nxt;
    logic             busy_nxt;
    logic             timeout_nxt;

    // Winner of the round-robin search: first set request at or after ptr.
    logic [2:0]       win;
    logic             win_vld;

    // Scanning offsets from the far end down to zero leaves the smallest
    // offset, i.e. the nearest requester after ptr, as the final assignment.
    // The 3-bit sum wraps 7 -> 0 naturally.
    always_comb begin
        win     = 3'd0;
        win_vld = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                win     = ptr + 3'(k);
                win_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        sel_nxt     = sel;
        gnt_nxt     = gnt;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                // done is ignored here; sel keeps the last owner's index.
                if (win_vld) begin
                    state_nxt = GRANT;
                    sel_nxt   = win;
                    gnt_nxt   = 8'b1 << win;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                end
            end

            GRANT: begin
                // Only the owner's request and done matter while granted;
                // other requesters wait for the release.
                if (done || !req[sel] || (cnt == CNT_W'(HOLD_MAX))) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = 8'd0;
                    busy_nxt    = 1'b0;
                    cnt_nxt     = '0;
                    ptr_nxt     = sel + 3'd1;
                    // A normal finish takes precedence over the hold limit,
                    // so timeout only fires when the owner is still active.
                    timeout_nxt = !(done || !req[sel]);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 8'd0;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            cnt     <= '0;
            sel     <= 3'd0;
            gnt     <= 8'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            sel     <= sel_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//
// Scoreboard bench for mux8_rr_arbiter. The driver applies req/done on the
// falling edge, advances a behavioural model of the arbiter by one clock and
// pushes the outputs expected after the next rising edge into a queue. The
// monitor pops one entry shortly after every rising edge and compares it
// with the DUT outputs.
//
// The model keeps the owner as an integer (-1 = none), the pointer as an
// integer and finds the winner with a modulo-8 scan over requester indices.
// -----------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

    localparam int HOLD_MAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'd0;
    logic       done = 1'b0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_owner = -1;   // index of current owner, -1 when idle
    int m_held  = 0;    // cycles the current owner has held the mux
    int m_ptr   = 0;    // first index searched at the next arbitration
    int m_sel   = 0;    // last granted index
    bit m_to    = 1'b0;

    task automatic check(input string name, input logic [7:0] actual,
                         input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time,
                     actual, expected);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_to    = 1'b0;
    endtask

    // One clock of arbiter behaviour for the given inputs.
    task automatic model_step(input logic [7:0] r, input logic d);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (r != 8'd0) begin
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 8;
                    if (r[idx] && m_owner < 0) begin
                        m_owner = idx;
                        m_sel   = idx;
                        m_held  = 1;
                    end
                end
            end
        end else if (d || !r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else if (m_held == HOLD_MAX) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    // Drive one cycle of stimulus and record what the DUT must show after it.
    task automatic step(input logic [7:0] r, input logic d);
        exp_t e;
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
        e.sel     = 3'(m_sel);
        e.gnt     = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.busy    = (m_owner >= 0);
        e.timeout = m_to;
        exp_q.push_back(e);
    endtask

    // Assert reset away from any clock edge and check outputs immediately.
    task automatic async_reset(input string tag);
        req  = 8'd0;
        done = 1'b0;
        rst  = 1'b1;
        #1;
        model_reset();
        check({tag, "_gnt"},     gnt,          8'd0);
        check({tag, "_busy"},    {7'd0, busy}, 8'd0);
        check({tag, "_sel"},     {5'd0, sel},  8'd0);
        check({tag, "_timeout"}, {7'd0, timeout}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare one expected entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sel",     {5'd0, sel},     {5'd0, e.sel});
                check("gnt",     gnt,             e.gnt);
                check("busy",    {7'd0, busy},    {7'd0, e.busy});
                check("timeout", {7'd0, timeout}, {7'd0, e.timeout});
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic       d;

        // Reset, then idle with no requests.
        #2;
        async_reset("reset");
        for (int i = 0; i < 10; i++) step(8'h00, 1'b0);

        // Single requester, done two cycles after the grant.
        step(8'h01, 1'b0);
        step(8'h01, 1'b0);
        step(8'h01, 1'b1);
        step(8'h01, 1'b0);
        step(8'h01, 1'b1);
        step(8'h00, 1'b0);

        // All requesting, done on each grant: order walks and wraps.
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 1'b0);
            step(8'hFF, 1'b1);
        end
        step(8'h00, 1'b0);

        // Two requesters holding without done: forced release each time.
        for (int i = 0; i < 18; i++) step(8'h24, 1'b0);
        step(8'h00, 1'b0);

        // Done together with the hold limit counts as a normal release.
        step(8'h02, 1'b0);
        for (int i = 0; i < HOLD_MAX - 1; i++) step(8'h02, 1'b0);
        step(8'h02, 1'b1);
        step(8'h00, 1'b0);

        // Owner 3 drops its request and pulses done in the same cycle.
        step(8'h08, 1'b0);
        step(8'h88, 1'b0);
        step(8'h80, 1'b1);
        step(8'h88, 1'b0);
        step(8'h88, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b1);   // done while idle is ignored
        step(8'h00, 1'b0);

        // Randomised phase: slowly changing levels, sporadic done pulses.
        r = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) r = 8'($urandom);
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            d = ($urandom_range(0, 4) == 0);
            step(r, d);
        end
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Reset while requester 6 owns the mux.
        for (int i = 0; i < 3 && m_owner != 6; i++) step(8'h40, 1'b0);
        step(8'h40, 1'b0);
        @(posedge clk);
        #2;
        async_reset("midrst");
        step(8'h41, 1'b0);
        step(8'h41, 1'b1);
        step(8'h41, 1'b0);
        step(8'h41, 1'b1);
        step(8'h00, 1'b0);

        // Let the monitor drain the queue.
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
